stage_ifetch_queue: RTL
=======================

# stage_ifetch_queue

Prefetching instruction-fetch stage for the CPU pipeline. It owns the program counter, fetches opcodes from instruction memory into a DEPTH-entry queue, and hands them to the decode stage over a valid/ack handshake. A single-cycle redirect flushes the queue and restarts fetch at a new address for loop branches. Memory latency is decoupled from decode stalls.

## Interface
- A_WIDTH, 12, instruction address width
- D_WIDTH, 8, opcode width
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-low; 0 at a posedge resets all state
- ice  out  1  instruction memory read enable
- ia  out  A_WIDTH  instruction memory address, equal to fetch_pc
- id  in  D_WIDTH  instruction memory data; combinational read, valid in the same cycle as ice/ia
- redirect  in  1  flush the queue and restart fetch at redirect_pc
- redirect_pc  in  A_WIDTH  new fetch address
- valid  out  1  queue head holds an opcode
- opcode  out  D_WIDTH  head opcode; 0 when valid=0
- opcode_pc  out  A_WIDTH  address of the head opcode; 0 when valid=0
- ack_in  in  1  decode accepts the head; effective only when valid=1
- level  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH

## Operation
- State: fetch_pc (A_WIDTH), queue of DEPTH entries {pc, opcode}, rd_ptr and wr_ptr ($clog2(DEPTH) bits, wrapping), count (0..DEPTH).
- Fetch: ice = reset && !redirect && (count != DEPTH). There is no write-through-when-full: a pop from a full queue does not allow a fetch in the same cycle.
- Push: when ice=1, write {fetch_pc, id} at wr_ptr, increment wr_ptr, and set fetch_pc ← fetch_pc + 1, modulo 2^A_WIDTH (e.g. 0xFFF → 0x000 at A_WIDTH=12).
- Pop: when valid && ack_in && !redirect, increment rd_ptr. ack_in with valid=0 has no effect.
- Count:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Outputs: valid = (count != 0), level = count. opcode and opcode_pc are driven combinationally from entry rd_ptr, gated to 0 when empty.
- Redirect, which has priority over push and pop:
  - at the posedge, count, rd_ptr and wr_ptr become 0 and fetch_pc ← redirect_pc
  - no memory read happens that cycle; an ack_in in the same cycle is discarded, and decode must treat that head as consumed by the branch
- Reset (reset=0 at a posedge) has priority over everything, including redirect. fetch_pc, count and pointers become 0.
- Reset values: ice=0 while reset=0; ia=0 after the reset edge; valid=0, opcode=0, opcode_pc=0, level=0.

## Timing
- ice and ia are combinational from registered state and redirect. opcode, opcode_pc, valid and level are combinational from registered state only, with no path from ack_in.
- Fill latency: an opcode fetched in cycle N is visible at the head (valid=1) in cycle N+1.
- Reset release: in the first cycle with reset=1, ice=1 and ia=0. valid=1 with opcode_pc=0 follows one cycle later.
- Steady state with ack_in held at 1: one push and one pop per cycle, level constant at 1, throughput one opcode per cycle.
- Decode stall (ack_in=0): the queue fills to DEPTH in DEPTH cycles, then ice=0 and fetch_pc holds.
- Redirect in cycle N: ice=0 in N. In N+1, valid=0 and ice=1 with ia=redirect_pc. In N+2, valid=1 with opcode_pc=redirect_pc.
- Mid-operation reset behaves exactly like reset from power-up. Queued entries are lost.

## Test plan
- Reset then stream: memory holds id=addr[7:0], ack_in=1 after reset release → valid rises one cycle after reset release; opcode_pc sequence 0,1,2,… with opcode = low byte of address; level stays ≤1.
- Stall and full: ack_in=0 for 8 cycles, DEPTH=4 → level goes 1,2,3,4,4…; ice=0 from level 4; ia holds at 4. Then ack_in=1 → heads 0,1,2,3 in order, and a fetch resumes the cycle after the first pop.
- Simultaneous push/pop at level 2 → level stays 2 and order is preserved.
- Redirect to 0x123 while level=3 and ack_in=1 → next cycle valid=0, level=0, ia=0x123; the cycle after that, opcode_pc=0x123.
- Wrap: redirect to 0xFFE, A_WIDTH=12 → opcode_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Reset mid-stream at level 3, together with redirect=1 → all outputs 0 and ice=0 while reset=0; after release, fetch restarts at 0, not at redirect_pc.

Source files
------------

// File: rtl/stage_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : stage_ifetch_queue
// Description : Prefetching instruction-fetch stage. Owns the program counter,
//               fetches opcodes from a combinational-read instruction memory
//               into a DEPTH-entry queue and presents the head to decode over
//               a valid/ack handshake. A redirect flushes the queue and
//               restarts fetch at a new address.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ifetch_queue #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ice,
  output logic [A_WIDTH-1:0]       ia,
  input  logic [D_WIDTH-1:0]       id,
  input  logic                     redirect,
  input  logic [A_WIDTH-1:0]       redirect_pc,
  output logic                     valid,
  output logic [D_WIDTH-1:0]       opcode,
  output logic [A_WIDTH-1:0]       opcode_pc,
  input  logic                     ack_in,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  // Architectural state
  logic [A_WIDTH-1:0] r_fetch_pc;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  // Queue storage; contents are don't-care until count says otherwise,
  // so the entries themselves carry no reset.
  logic [A_WIDTH-1:0] r_pc_mem [DEPTH];
  logic [D_WIDTH-1:0] r_op_mem [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_not_empty;

  // Fetch is suppressed during reset, during a redirect cycle and when full.
  // A pop from a full queue deliberately does not open a slot in the same
  // cycle, which keeps ice free of any path from ack_in.
  always_comb begin
    w_not_empty = (r_count != '0);
    w_push      = reset && !redirect && (r_count != C_FULL);
    w_pop       = w_not_empty && ack_in && !redirect;
  end

  // Memory-side and decode-side outputs
  always_comb begin
    ice       = w_push;
    ia        = r_fetch_pc;
    valid     = w_not_empty;
    level     = r_count;
    opcode    = w_not_empty ? r_op_mem[r_rd_ptr] : '0;
    opcode_pc = w_not_empty ? r_pc_mem[r_rd_ptr] : '0;
  end

  // Queue entry write on every fetch
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr] <= r_fetch_pc;
      r_op_mem[r_wr_ptr] <= id;
    end
  end

  // Control state: reset beats redirect, redirect beats push/pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
